scratchpad_port_arbiter: RTL and testbench

SCRATCHPAD_PORT_ARBITER -- requirements
Module: scratchpad_port_arbiter

---
 rtl/scratchpad_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_scratchpad_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_port_arbiter.sv
// scratchpad_port_arbiter
//
// Shares port B of a scratchpad SRAM (1-cycle read latency) between NUM_REQ
// compute-side requesters.
//
// Arbitration
//   ARB  : round-robin starting at rr_ptr. The first valid requester is granted.
//   HOLD : a requester whose granted beat carries req_lock keeps the port.
//          It keeps the port until one of these happens:
//            - it sends an unlocked beat,
//            - it drops req_valid (nobody is granted in that cycle),
//            - MAX_HOLD consecutive beats have elapsed while someone else waits.
//          On expiry the owner is excluded for one round-robin pass.
//          If nobody else is waiting, the hold simply continues and hold_cnt
//          saturates at MAX_HOLD.
//
// Read data returns one cycle after the grant on a shared bus (rsp_rdata).
// The bus is qualified by a one-hot rsp_valid. Between responses rsp_rdata
// keeps its last value.
//
// Optional build macro: SCRATCHPAD_ARB_PERF_EN
//   Adds output stall_cnt: one 32-bit saturating counter per requester,
//   counting cycles spent waiting (valid without ready).
module scratchpad_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          sram_en,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
`ifdef SCRATCHPAD_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]         stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]         sram_dout
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;       // locked requester while in HOLD
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d; // consecutive locked beats so far
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;     // round-robin search start
  logic [NUM_REQ-1:0]    rsp_valid_q;            // read issued last cycle, one-hot
  logic [DATA_WIDTH-1:0] rdata_q;                // last delivered read word

  // ---------------------------------------------------------------------------
  // Arbitration helpers
  // ---------------------------------------------------------------------------
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [NUM_REQ-1:0]    others_valid;
  logic                  owner_valid;
  logic                  hold_expired;

  // First set bit of cand, searching upward from ptr and wrapping.
  // Returns ptr when cand is empty; callers only use the result when cand != 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = ptr;
    // Walk downward so the lowest offset from ptr is the last one written and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (cand[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign owner_oh     = NUM_REQ'(1) << owner_q;
  assign others_valid = req_valid & ~owner_oh;
  assign owner_valid  = |(req_valid & owner_oh);
  assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD)) && (|others_valid);

  // ---------------------------------------------------------------------------
  // State register: synchronous active-high reset
  // ---------------------------------------------------------------------------
  // NOTE: registers take non-blocking assignments so that every flop samples
  // the pre-edge values, independent of the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      // Only reads produce a response, one cycle after their grant.
      rsp_valid_q <= (grant_vld && !sram_we) ? req_ready : '0;
      if (|rsp_valid) rdata_q <= sram_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: follows the beat that was granted this cycle
  // ---------------------------------------------------------------------------
  // NOTE: each variable gets a default first, so no path through the block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
      if (req_lock[grant_idx]) begin
        state_d = ST_HOLD;
        owner_d = grant_idx;
        if (state_q == ST_HOLD && grant_idx == owner_q) begin
          // Continuing the same hold: count up, saturating at MAX_HOLD.
          if (hold_cnt_q != CNT_W'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
          hold_cnt_d = CNT_W'(1);
        end
      end else begin
        state_d    = ST_ARB;
        hold_cnt_d = '0;
      end
    end else if (state_q == ST_HOLD) begin
      // The owner dropped valid: release the port.
      state_d    = ST_ARB;
      hold_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: pick this cycle's grant and steer it onto the SRAM port
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    if (!rst) begin
      if (state_q == ST_ARB) begin
        grant_vld = |req_valid;
        grant_idx = rr_pick(req_valid, rr_ptr_q);
      end else if (owner_valid) begin
        grant_vld = 1'b1;
        // On hold expiry the owner sits out one pass if anyone else waits.
        grant_idx = hold_expired ? rr_pick(others_valid, rr_ptr_q) : owner_q;
      end
    end
    req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    sram_en   = grant_vld;
    sram_we   = grant_vld & req_we[grant_idx];
    sram_addr = req_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sram_din  = req_wdata[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  // A read in flight when reset arrives is dropped.
  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_rdata = (|rsp_valid) ? sram_dout : rdata_q;

`ifdef SCRATCHPAD_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Stall counters: cycles a requester waits with a request pending
  // ---------------------------------------------------------------------------
  logic [31:0] stall_q [NUM_REQ];

  // Count valid-without-ready cycles per requester, saturating at all-ones.
  // NOTE: unlike a data RAM, this register array is software-visible, so every
  // entry must be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && stall_q[i] != '1)
          stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall_out
    assign stall_cnt[gi*32 +: 32] = stall_q[gi];
  end
`endif

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Testbench for scratchpad_port_arbiter.
//
// Structure
//   - A behavioural SRAM model answers port B with 1-cycle read latency.
//   - A negedge process holds a reference model of the arbitration rules.
//     Each cycle it compares every meaningful DUT output against that model.
//   - Directed tests capture grants and responses and compare them against
//     hand-computed literals.
module tb_scratchpad_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic [DW-1:0]   sram_dout = '0;
`ifdef SCRATCHPAD_ARB_PERF_EN
  logic [N*32-1:0] stall_cnt;
`endif

  scratchpad_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
`ifdef SCRATCHPAD_ARB_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-up contents of unwritten SRAM words.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {16'hA5C3, 3'b000, a};
  endfunction

  // ---------------------------------------------------------------------------
  // SRAM model (port B)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] = sram_din;
      else sram_dout <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_val(sram_addr);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle comparison
  // ---------------------------------------------------------------------------
  int            m_owner = -1;  // locked requester, -1 when arbitrating freely
  int            m_cnt   = 0;   // beats granted in the current hold
  int            m_rr    = 0;   // round-robin start
  bit            m_pend  = 1'b0;
  int            m_pidx  = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] m_last  = '0;
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  int            m_stall [N];
  int            mg;
  logic [AW-1:0] ma;
  logic [N-1:0]  m_others;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_sram_en",   64'(sram_en),   64'd0);
      check("rst_sram_we",   64'(sram_we),   64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      m_owner = -1; m_cnt = 0; m_rr = 0; m_pend = 1'b0; m_last = '0;
      for (int i = 0; i < N; i++) m_stall[i] = 0;
    end else begin
      // Response to last cycle's read, or the held last value.
      check("rsp_valid", 64'(rsp_valid), m_pend ? 64'(3'b001 << m_pidx) : 64'd0);
      if (m_pend) begin
        check("rsp_rdata", 64'(rsp_rdata), 64'(m_pdata));
        m_last = m_pdata;
      end else begin
        check("rsp_rdata_hold", 64'(rsp_rdata), 64'(m_last));
      end
`ifdef SCRATCHPAD_ARB_PERF_EN
      for (int i = 0; i < N; i++)
        check($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
`endif
      // Who owns the port this cycle.
      if (m_owner >= 0) begin
        m_others = req_valid & ~(3'b001 << m_owner);
        if (!req_valid[m_owner]) begin
          mg = -1;
          m_owner = -1;
        end else if (m_cnt >= MH && m_others != 0) begin
          mg = pick(m_others, m_rr);
        end else begin
          mg = m_owner;
        end
      end else begin
        mg = pick(req_valid, m_rr);
      end
      check("req_ready", 64'(req_ready), (mg >= 0) ? 64'(3'b001 << mg) : 64'd0);
      check("sram_en",   64'(sram_en),   (mg >= 0) ? 64'd1 : 64'd0);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && i != mg) m_stall[i]++;
      m_pend = 1'b0;
      if (mg >= 0) begin
        ma = req_addr[mg*AW +: AW];
        check("sram_we",   64'(sram_we),   64'(req_we[mg]));
        check("sram_addr", 64'(sram_addr), 64'(ma));
        if (req_we[mg]) begin
          check("sram_din", 64'(sram_din), 64'(req_wdata[mg*DW +: DW]));
          m_mem[ma] = req_wdata[mg*DW +: DW];
        end else begin
          m_pend  = 1'b1;
          m_pidx  = mg;
          m_pdata = m_mem.exists(ma) ? m_mem[ma] : init_val(ma);
        end
        m_rr = (mg + 1) % N;
        if (req_lock[mg]) begin
          if (mg == m_owner) begin
            if (m_cnt < MH) m_cnt++;
          end else begin
            m_owner = mg;
            m_cnt   = 1;
          end
        end else begin
          m_owner = -1;
        end
      end else begin
        check("sram_we_idle", 64'(sram_we), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [N-1:0]  cap_ready, cap_rsp;
  logic [DW-1:0] cap_rdata;
  int            cap_hold;

  // One clock: sample the outputs mid-cycle, then return just after the next
  // rising edge, where new inputs can be driven.
  task automatic cycle();
    @(negedge clk);
    cap_ready = req_ready;
    cap_rsp   = rsp_valid;
    cap_rdata = rsp_rdata;
    cap_hold  = int'(dut.hold_cnt_q);
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh == (3'b001 << i)) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_lock[i]           = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic clear_all();
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    cycle();
    rst = 1'b0;
  endtask

  // Pattern table: per step, the valid / write / lock masks.
  logic [N-1:0] t6_v  [8] = '{3'b111, 3'b101, 3'b110, 3'b110, 3'b011, 3'b100, 3'b001, 3'b111};
  logic [N-1:0] t6_we [8] = '{3'b010, 3'b101, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000, 3'b111};
  logic [N-1:0] t6_lk [8] = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};

  int rec [64];
  int beats, run, gaps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_all();
    cycle();
    cycle();
    rst = 1'b0;

    // --- All three requesters reading every cycle: grants rotate 0,1,2,... ---
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(13'h100 + i), '0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      rec[c] = oh2idx(cap_ready);
      if (c == 1) begin
        check("t1_rsp_after_first", 64'(cap_rsp), 64'h1);
        check("t1_rdata_first", 64'(cap_rdata), 64'hA5C3_0100);
      end
    end
    for (int c = 0; c < 6; c++) check($sformatf("t1_grant%0d", c), 64'(rec[c]), 64'(c % 3));
    clear_all();
    cycle();

    // --- Write by req 1, then read-back by req 2 ---
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b0, 13'h0010, 32'hDEADBEEF);
    cycle();
    check("t2_write_grant", 64'(cap_ready), 64'b010);
    clear_all();
    set_req(2, 1'b1, 1'b0, 1'b0, 13'h0010, '0);
    cycle();
    check("t2_read_grant", 64'(cap_ready), 64'b100);
    check("t2_no_rsp_on_write", 64'(cap_rsp), 64'd0);
    clear_all();
    cycle();
    check("t2_rsp_valid", 64'(cap_rsp), 64'b100);
    check("t2_rsp_rdata", 64'(cap_rdata), 64'hDEADBEEF);
    cycle();
    check("t2_rdata_held", 64'(cap_rdata), 64'hDEADBEEF);

    // --- Locked 20-read burst by req 0 while req 1 waits ---
    do_reset();
    beats = 0;
    for (int c = 0; c < 64; c++) rec[c] = -1;
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h0200, '0);
    for (int c = 0; c < 40 && beats < 20; c++) begin
      set_req(0, 1'b1, 1'b0, (beats < 19), AW'(13'h0300 + beats), '0);
      cycle();
      rec[c] = oh2idx(cap_ready);
      if (rec[c] == 0) beats++;
    end
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    clear_all();
    cycle();
    run = 0;
    while (run < 64 && rec[run] == 0) run++;
    check("t3_first_run_len", 64'(run), 64'd16);
    check("t3_grant17_req1", 64'(rec[16]), 64'd1);
    check("t3_req0_resumes", 64'(rec[17]), 64'd0);
    check("t3_all_beats", 64'(beats), 64'd20);

    // --- Locked req 0 alone for 40 beats: never interrupted ---
    do_reset();
    beats = 0;
    gaps  = 0;
    for (int c = 0; c < 60 && beats < 40; c++) begin
      set_req(0, 1'b1, 1'b0, (beats < 39), AW'(13'h0400 + beats), '0);
      cycle();
      if (cap_ready == 3'b001) begin
        beats++;
        if (beats == 30) check("t4_hold_cnt_saturated", 64'(cap_hold), 64'd16);
      end else begin
        gaps++;
      end
    end
    check("t4_beats", 64'(beats), 64'd40);
    check("t4_no_gaps", 64'(gaps), 64'd0);
    clear_all();
    cycle();

    // --- Reset in the middle of a hold with a read in flight ---
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_req(1, 1'b1, 1'b0, 1'b1, AW'(13'h0070 + c), '0);
      cycle();
    end
    check("t5_pre_hold_grant", 64'(cap_ready), 64'b010);
    rst = 1'b1;
    cycle();
    check("t5_rst_ready", 64'(cap_ready), 64'd0);
    check("t5_rst_rsp", 64'(cap_rsp), 64'd0);
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h0080, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 13'h0081, '0);
    cycle();
    check("t5_no_rsp_after_rst", 64'(cap_rsp), 64'd0);
    check("t5_first_grant_lowest", 64'(cap_ready), 64'b010);
    clear_all();
    cycle();
    cycle();

    // --- Mixed read/write/lock patterns from a table ---
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++)
        set_req(i, t6_v[s][i], t6_we[s][i], t6_lk[s][i],
                t6_we[s][i] ? AW'(13'h0040 + i) : AW'(13'h0040 + (i + 1) % N),
                32'(32'hBEE0_0000 + s * 16 + i));
      cycle();
    end
    clear_all();
    cycle();
    cycle();

`ifdef SCRATCHPAD_ARB_PERF_EN
    // --- Stall counters: req 1 plain reads, req 2 locked reads, 10 cycles ---
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h0050, '0);
    set_req(2, 1'b1, 1'b0, 1'b1, 13'h0060, '0);
    repeat (10) cycle();
    clear_all();
    cycle();
    check("t7_stall1", 64'(stall_cnt[32 +: 32]), 64'd9);
    check("t7_stall2", 64'(stall_cnt[64 +: 32]), 64'd1);
    check("t7_stall0", 64'(stall_cnt[0 +: 32]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
